// File: rtl/spi_adc_seq.sv
// SPI ADC sweep sequencer: mode-0 master for a pipelined ADC (result of frame n belongs to frame n-1's address).
// Optional macro SPI_ADC_SEQ_AVG_EN: convert each channel 4 times and report the truncated mean.
module spi_adc_seq #(
  parameter int DATA_W    = 16,
  parameter int CH_N      = 4,
  parameter int CH_AW     = 2,
  parameter int CLK_DIV   = 2,
  parameter int FRAME_GAP = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cont,
  input  logic [CH_N-1:0]   ch_mask,
  input  logic              rvs,
  input  logic              miso,
  output logic              cs,
  output logic              sclk,
  output logic              mosi,
  output logic [DATA_W-1:0] dout,
  output logic [CH_AW-1:0]  dout_ch,
  output logic              dout_vld,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  localparam int                BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [15:0]       DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0]       GAP_LAST = 16'(FRAME_GAP - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RVS = 3'd1,
    CS_SETUP = 3'd2,
    SHIFT    = 3'd3,
    CS_HOLD  = 3'd4,
    GAP      = 3'd5
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [15:0]         r_cnt;
  logic [BIT_W-1:0]    r_bit;
  logic                r_sclk;
  logic [DATA_W-1:0]   r_miso_sr, r_mosi_sr;
  logic [CH_N-1:0]     r_mask;
  logic [CH_AW-1:0]    r_addr, r_nxt_addr, r_prev_ch;
  logic                r_flush, r_nxt_flush, r_prev_vld;
  logic [DATA_W-1:0]   r_dout;
  logic [CH_AW-1:0]    r_dout_ch;
  logic                r_dout_vld;
`ifdef SPI_ADC_SEQ_AVG_EN
  logic [1:0]          r_rep, r_prev_rep;
  logic [DATA_W+1:0]   r_acc;
  logic [DATA_W+1:0]   w_acc_sum;
`endif

  logic                w_div_end, w_rise, w_fall, w_shift_done;
  logic                w_hold_done, w_gap_done, w_start, w_load;
  logic [CH_AW:0]      w_nxt_hi;
  logic [CH_AW-1:0]    w_nxt_addr;
  logic                w_nxt_flush, w_relatch;

  function automatic logic [CH_AW-1:0] f_lowest(input logic [CH_N-1:0] m);
    logic [CH_AW-1:0] res;
    res = '0;
    for (int i = CH_N - 1; i >= 0; i--)
      if (m[i]) res = CH_AW'(i);
    return res;
  endfunction

  // Returns {found, addr} of the lowest enabled channel above cur.
  function automatic logic [CH_AW:0] f_next(input logic [CH_N-1:0] m, input logic [CH_AW-1:0] cur);
    logic [CH_AW:0] res;
    res = '0;
    for (int i = CH_N - 1; i >= 0; i--)
      if (m[i] && (i > int'(cur))) res = {1'b1, CH_AW'(i)};
    return res;
  endfunction

  assign w_div_end    = (r_cnt == DIV_LAST);
  assign w_rise       = (r_state == SHIFT) && w_div_end && !r_sclk;
  assign w_fall       = (r_state == SHIFT) && w_div_end && r_sclk;
  assign w_shift_done = w_fall && (r_bit == BIT_LAST);
  assign w_hold_done  = (r_state == CS_HOLD) && w_div_end;
  assign w_gap_done   = (r_state == GAP) && (r_cnt == GAP_LAST);
  assign w_start      = (r_state == IDLE) && start && (|ch_mask);
  assign w_load       = (r_state == WAIT_RVS) && rvs;

  // Address for the frame after the one being loaded; cont is sampled here.
  always_comb begin
    w_nxt_hi    = f_next(r_mask, r_addr);
    w_nxt_addr  = r_addr;
    w_nxt_flush = 1'b0;
    w_relatch   = 1'b0;
    if (w_nxt_hi[CH_AW]) begin
      w_nxt_addr = w_nxt_hi[CH_AW-1:0];
    end else if (cont && (|ch_mask)) begin
      w_relatch  = 1'b1;
      w_nxt_addr = f_lowest(ch_mask);
    end else begin
      w_nxt_flush = 1'b1;
      w_nxt_addr  = f_lowest(r_mask);
    end
`ifdef SPI_ADC_SEQ_AVG_EN
    if (r_rep != 2'd3) begin
      w_nxt_addr  = r_addr;
      w_nxt_flush = 1'b0;
      w_relatch   = 1'b0;
    end
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:     if (w_start) w_state_nxt = WAIT_RVS;
      WAIT_RVS: if (rvs) w_state_nxt = CS_SETUP;
      CS_SETUP: w_state_nxt = SHIFT;
      SHIFT:    if (w_shift_done) w_state_nxt = CS_HOLD;
      CS_HOLD:  if (w_div_end) w_state_nxt = GAP;
      GAP:      if (w_gap_done) w_state_nxt = r_flush ? IDLE : WAIT_RVS;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

`ifdef SPI_ADC_SEQ_AVG_EN
  assign w_acc_sum = ((r_prev_rep == 2'd0) ? '0 : r_acc) + {2'b00, r_miso_sr};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_bit       <= '0;
      r_sclk      <= 1'b0;
      r_miso_sr   <= '0;
      r_mosi_sr   <= '0;
      r_mask      <= '0;
      r_addr      <= '0;
      r_nxt_addr  <= '0;
      r_prev_ch   <= '0;
      r_flush     <= 1'b0;
      r_nxt_flush <= 1'b0;
      r_prev_vld  <= 1'b0;
      r_dout      <= '0;
      r_dout_ch   <= '0;
      r_dout_vld  <= 1'b0;
`ifdef SPI_ADC_SEQ_AVG_EN
      r_rep       <= '0;
      r_prev_rep  <= '0;
      r_acc       <= '0;
`endif
    end else begin
      r_dout_vld <= 1'b0;
      if ((w_state_nxt != r_state) || ((r_state == SHIFT) && w_div_end))
        r_cnt <= '0;
      else if (r_state inside {SHIFT, CS_HOLD, GAP})
        r_cnt <= r_cnt + 16'd1;

      if (w_rise) begin
        r_sclk    <= 1'b1;
        r_miso_sr <= {r_miso_sr[DATA_W-2:0], miso};
      end
      if (w_fall) begin
        r_sclk    <= 1'b0;
        r_mosi_sr <= {r_mosi_sr[DATA_W-2:0], 1'b0};
        r_bit     <= r_bit + BIT_W'(1);
      end

      if (w_start) begin
        r_mask     <= ch_mask;
        r_addr     <= f_lowest(ch_mask);
        r_flush    <= 1'b0;
        r_prev_vld <= 1'b0;
`ifdef SPI_ADC_SEQ_AVG_EN
        r_rep      <= '0;
`endif
      end

      if (w_load) begin
        r_mosi_sr   <= {r_addr, {(DATA_W - CH_AW){1'b0}}};
        r_bit       <= '0;
        r_nxt_addr  <= w_nxt_addr;
        r_nxt_flush <= w_nxt_flush;
        if (w_relatch && !r_flush) r_mask <= ch_mask;
      end

      // The word shifted in now answers the previous frame's address.
      if (w_hold_done) begin
        r_prev_ch  <= r_addr;
        r_prev_vld <= !r_flush;
`ifdef SPI_ADC_SEQ_AVG_EN
        r_prev_rep <= r_rep;
        if (r_prev_vld) begin
          r_acc <= w_acc_sum;
          if (r_prev_rep == 2'd3) begin
            r_dout     <= w_acc_sum[DATA_W+1:2];
            r_dout_ch  <= r_prev_ch;
            r_dout_vld <= 1'b1;
          end
        end
`else
        if (r_prev_vld) begin
          r_dout     <= r_miso_sr;
          r_dout_ch  <= r_prev_ch;
          r_dout_vld <= 1'b1;
        end
`endif
      end

      if (w_gap_done && !r_flush) begin
        r_addr  <= r_nxt_addr;
        r_flush <= r_nxt_flush;
`ifdef SPI_ADC_SEQ_AVG_EN
        r_rep   <= r_rep + 2'd1;
`endif
      end
    end
  end

  assign cs        = !(r_state inside {CS_SETUP, SHIFT, CS_HOLD});
  assign sclk      = r_sclk;
  assign mosi      = r_mosi_sr[DATA_W-1];
  assign dout      = r_dout;
  assign dout_ch   = r_dout_ch;
  assign dout_vld  = r_dout_vld;
  assign busy      = (r_state != IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_spi_adc_seq.sv
// Directed bench for spi_adc_seq: pipelined ADC slave model, result/address queues, frame monitor.
module tb_spi_adc_seq;

  logic        clk, rst_n, start, cont, rvs, miso;
  logic [3:0]  ch_mask;
  logic        cs, sclk, mosi, dout_vld, busy;
  logic [15:0] dout;
  logic [1:0]  dout_ch;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  spi_adc_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .ch_mask(ch_mask),
    .rvs(rvs), .miso(miso), .cs(cs), .sclk(sclk), .mosi(mosi), .dout(dout),
    .dout_ch(dout_ch), .dout_vld(dout_vld), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ADC slave model: returns adc_val of the address received in the previous frame
  logic [15:0] adc_val [4];
  logic [15:0] samp_q [$];
  logic [15:0] tx_sr;
  logic [1:0]  rx_sr, rx_prev;
  int          rx_bits;
  logic [1:0]  addr_q [$];

  initial begin
    miso = 1'b0; rx_prev = 2'd0; rx_sr = 2'd0; rx_bits = 0; tx_sr = 16'd0;
  end

  always @(negedge cs) begin
    if (samp_q.size() != 0) tx_sr = samp_q.pop_front();
    else                    tx_sr = adc_val[rx_prev];
    miso = tx_sr[15];
    rx_bits = 0;
    rx_sr = 2'd0;
  end
  always @(negedge sclk) if (!cs) begin
    tx_sr = {tx_sr[14:0], 1'b0};
    miso = tx_sr[15];
  end
  always @(posedge sclk) if (!cs) begin
    if (rx_bits < 2) rx_sr = {rx_sr[0], mosi};
    rx_bits++;
  end
  always @(posedge cs) begin
    rx_prev = rx_sr;
    addr_q.push_back(rx_sr);
  end

  // monitor
  logic [17:0] got_q [$];
  logic [17:0] exp_q [$];
  logic [1:0]  exp_a [$];
  int frames = 0, low_cnt = 0, last_low = 0, cs_low_seen = 0, sclk_err = 0, vld_err = 0;
  logic prev_cs = 1'b1, prev_vld = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cs = 1'b1; prev_vld = 1'b0; low_cnt = 0;
    end else begin
      if (prev_cs && !cs) frames++;
      if (!cs) begin low_cnt++; cs_low_seen++; end
      if (!prev_cs && cs) begin last_low = low_cnt; low_cnt = 0; end
      if (cs && sclk) sclk_err++;
      if (dout_vld) begin
        got_q.push_back({dout_ch, dout});
        if (prev_vld || !(cs && !prev_cs)) vld_err++;
      end
      prev_vld = dout_vld;
      prev_cs  = cs;
    end
  end

  // driver / checker tasks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic clear_q();
    got_q.delete(); exp_q.delete(); addr_q.delete(); exp_a.delete();
    frames = 0; cs_low_seen = 0; sclk_err = 0; vld_err = 0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(1); n++; end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    tick(2);
  endtask

  task automatic wait_frames(input string tag, input int target, input int budget);
    int n = 0;
    while (frames < target && n < budget) begin tick(1); n++; end
    chk({tag, "_reach_frame"}, {31'd0, frames >= target}, 32'd1);
  endtask

  task automatic check_sweep(input string tag, input int exp_frames);
    chk({tag, "_frames"}, frames, exp_frames);
    chk({tag, "_n_results"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_res%0d", tag, i), {14'd0, got_q[i]}, {14'd0, exp_q[i]});
    chk({tag, "_n_addr"}, addr_q.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < addr_q.size(); i++)
      chk($sformatf("%s_addr%0d", tag, i), {30'd0, addr_q[i]}, {30'd0, exp_a[i]});
    chk({tag, "_cs_low_len"}, last_low, 67);
    chk({tag, "_vld_shape"}, vld_err, 0);
    chk({tag, "_sclk_idle"}, sclk_err, 0);
  endtask

  // stimulus
  initial begin
    rst_n = 1'b0; start = 1'b0; cont = 1'b0; rvs = 1'b1; ch_mask = 4'd0;
    for (int c = 0; c < 4; c++) adc_val[c] = 16'hBFFF + 16'(c);
    tick(3);
    chk("rst_cs", {31'd0, cs}, 32'd1);
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_mosi", {31'd0, mosi}, 32'd0);
    chk("rst_dout", {16'd0, dout}, 32'd0);
    chk("rst_dout_ch", {30'd0, dout_ch}, 32'd0);
    chk("rst_vld", {31'd0, dout_vld}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    tick(2);

`ifdef SPI_ADC_SEQ_AVG_EN
    // four samples of ch0 averaged, then the flush frame
    clear_q();
    samp_q = '{16'd0, 16'd100, 16'd101, 16'd102, 16'd104};
    ch_mask = 4'b0001;
    pulse_start();
    wait_idle("avg", 3000);
    exp_q.push_back({2'd0, 16'd101});
    exp_a = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    check_sweep("avg", 5);
`else
    // start with an empty mask is ignored
    ch_mask = 4'b0000;
    pulse_start();
    tick(3);
    chk("empty_mask_busy", {31'd0, busy}, 32'd0);

    // full sweep
    clear_q();
    ch_mask = 4'b1111;
    pulse_start();
    chk("s1_busy", {31'd0, busy}, 32'd1);
    wait_idle("s1", 2000);
    exp_q = '{{2'd0, 16'hBFFF}, {2'd1, 16'hC000}, {2'd2, 16'hC001}, {2'd3, 16'hC002}};
    exp_a = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    check_sweep("s1", 5);

    // sparse mask; a second start while busy must not disturb the latched mask
    clear_q();
    adc_val[0] = 16'h1234; adc_val[2] = 16'hA5A5;
    ch_mask = 4'b0101;
    pulse_start();
    tick(10);
    ch_mask = 4'b1111;
    pulse_start();
    wait_idle("s2", 2000);
    exp_q = '{{2'd0, 16'h1234}, {2'd2, 16'hA5A5}};
    exp_a = '{2'd0, 2'd2, 2'd0};
    check_sweep("s2", 3);

    // rvs held low stalls the first frame; rvs dropping mid-frame does not abort it
    clear_q();
    adc_val[0] = 16'h5A0F;
    rvs = 1'b0;
    ch_mask = 4'b0001;
    pulse_start();
    tick(100);
    chk("s3_cs_stalled", cs_low_seen, 0);
    chk("s3_state_wait", {29'd0, dbg_state}, 32'd1);
    rvs = 1'b1;
    begin
      int n = 0;
      while (cs && n < 50) begin tick(1); n++; end
    end
    chk("s3_cs_fell", {31'd0, cs}, 32'd0);
    rvs = 1'b0;
    tick(20);
    rvs = 1'b1;
    wait_idle("s3", 2000);
    exp_q = '{{2'd0, 16'h5A0F}};
    exp_a = '{2'd0, 2'd0};
    check_sweep("s3", 2);

    // continuous mode for two sweeps, then drop cont
    clear_q();
    for (int c = 0; c < 4; c++) adc_val[c] = 16'hBFFF + 16'(c);
    ch_mask = 4'b1111;
    cont = 1'b1;
    pulse_start();
    wait_frames("s4", 5, 1000);
    cont = 1'b0;
    wait_idle("s4", 3000);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) exp_q.push_back({2'(c), 16'hBFFF + 16'(c)});
    exp_a = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    check_sweep("s4", 9);

    // reset during bit 7 of the second frame
    clear_q();
    pulse_start();
    wait_frames("s5", 2, 1000);
    tick(30);
    chk("s5_in_shift", {29'd0, dbg_state}, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("s5_rst_cs", {31'd0, cs}, 32'd1);
    chk("s5_rst_sclk", {31'd0, sclk}, 32'd0);
    chk("s5_rst_busy", {31'd0, busy}, 32'd0);
    chk("s5_rst_dout", {16'd0, dout}, 32'd0);
    tick(3);
    chk("s5_no_result", got_q.size(), 0);
    chk("s5_rst_vld", {31'd0, dout_vld}, 32'd0);
    rst_n = 1'b1;
    tick(2);
    clear_q();
    ch_mask = 4'b0010;
    pulse_start();
    wait_idle("s5b", 2000);
    exp_q = '{{2'd1, 16'hC000}};
    exp_a = '{2'd1, 2'd1};
    check_sweep("s5b", 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
